program_loader: RTL and testbench

Writer side of the CPU's instruction fetch path: an 8-slot instruction memory that the operator fills one nibble at a time from switches and a debounced push button, and that the CPU reads combinationally by program-counter address. While a load is in progress it holds the CPU off. Once all eight slots are written it returns to run mode and flags the program as loaded. It replaces the hard-wired opcode/argument arrays in the CPU with loadable storage.

---
 rtl/program_loader_if.sv | 24 ++
 rtl/program_loader.sv | 106 ++++++++++
 tb/tb_program_loader.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/program_loader_if.sv
// Operator load port and CPU fetch port of the instruction store.
// master drives switches/strobe/PC; slave is the loader that owns the memory.
interface program_loader_if;
  logic       load_en;
  logic       strobe;
  logic [3:0] data_in;
  logic [2:0] fetch_addr;
  logic [3:0] fetch_opcode;
  logic [3:0] fetch_arg;
  logic [2:0] wr_addr;
  logic [1:0] load_state;
  logic       cpu_hold;
  logic       loaded;

  modport master (
    output load_en, strobe, data_in, fetch_addr,
    input  fetch_opcode, fetch_arg, wr_addr, load_state, cpu_hold, loaded
  );

  modport slave (
    input  load_en, strobe, data_in, fetch_addr,
    output fetch_opcode, fetch_arg, wr_addr, load_state, cpu_hold, loaded
  );
endinterface

// File: rtl/program_loader.sv
// 8-slot instruction store filled a nibble per strobe; fetch read is combinational, writes land on the strobe edge.
// load_en reaches the FSM three edges after it changes; cpu_hold stalls the CPU for the whole load.
module program_loader #(
  parameter int SLOTS = 8
) (
  input logic             clk,
  input logic             reset_n,
  program_loader_if.slave bus
);
  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LOAD_OP  = 2'b01,
    LOAD_ARG = 2'b10
  } state_t;

  state_t     state;
  logic [2:0] wr_addr;
  logic       loaded;
  logic       cpu_hold;
  logic [3:0] op_hold;
  logic       load_meta;
  logic       load_s;
  logic       load_s_q;
  logic [7:0] mem [SLOTS];

  logic load_rise;
  logic load_fall;

  // Only edges of the synchronized switch act, so a held switch never restarts a load.
  assign load_rise = load_s & ~load_s_q;
  assign load_fall = ~load_s & load_s_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= RUN;
      wr_addr   <= 3'd0;
      loaded    <= 1'b0;
      cpu_hold  <= 1'b0;
      op_hold   <= 4'h0;
      load_meta <= 1'b0;
      load_s    <= 1'b0;
      load_s_q  <= 1'b0;
      for (int i = 0; i < SLOTS; i++) begin
        mem[i] <= 8'h00;
      end
    end else begin
      load_meta <= bus.load_en;
      load_s    <= load_meta;
      load_s_q  <= load_s;

      case (state)
        RUN: begin
          if (load_rise) begin
            state    <= LOAD_OP;
            cpu_hold <= 1'b1;
            wr_addr  <= 3'd0;
            loaded   <= 1'b0;
          end
        end

        LOAD_OP: begin
          if (load_fall) begin
            state    <= RUN;
            cpu_hold <= 1'b0;
            op_hold  <= 4'h0;
          end else if (bus.strobe) begin
            op_hold <= bus.data_in;
            state   <= LOAD_ARG;
          end
        end

        LOAD_ARG: begin
          // An abort in the same cycle as a strobe drops the write.
          if (load_fall) begin
            state    <= RUN;
            cpu_hold <= 1'b0;
            op_hold  <= 4'h0;
          end else if (bus.strobe) begin
            mem[wr_addr] <= {op_hold, bus.data_in};
            if (wr_addr == 3'd7) begin
              wr_addr  <= 3'd0;
              loaded   <= 1'b1;
              state    <= RUN;
              cpu_hold <= 1'b0;
            end else begin
              wr_addr <= wr_addr + 3'd1;
              state   <= LOAD_OP;
            end
          end
        end

        default: begin
          state    <= RUN;
          cpu_hold <= 1'b0;
        end
      endcase
    end
  end

  assign bus.fetch_opcode = mem[bus.fetch_addr][7:4];
  assign bus.fetch_arg    = mem[bus.fetch_addr][3:0];
  assign bus.wr_addr      = wr_addr;
  assign bus.load_state   = state;
  assign bus.cpu_hold     = cpu_hold;
  assign bus.loaded       = loaded;
endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a nibble-count model checked every cycle, plus literal spot checks.
module tb_program_loader;
  logic clk = 1'b0;
  logic reset_n;

  program_loader_if bus();

  program_loader dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a load is a count of accepted nibbles (0..15); even counts take an opcode, odd counts write a slot.
  logic [7:0] m_mem [8];
  logic [2:0] m_hist;   // load_en samples, [0] newest; the controller acts on the one two edges old
  bit         m_loading;
  int         m_taken;
  bit         m_loaded;
  logic [3:0] m_op;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_hist    = 3'b000;
      m_loading = 0;
      m_taken   = 0;
      m_loaded  = 0;
      m_op      = 4'h0;
      for (int i = 0; i < 8; i++) m_mem[i] = 8'h00;
    end else begin
      bit seen_now, seen_prev;
      seen_now  = m_hist[1];
      seen_prev = m_hist[2];
      m_hist    = {m_hist[1:0], bus.load_en};
      if (!m_loading) begin
        if (seen_now && !seen_prev) begin
          m_loading = 1;
          m_taken   = 0;
          m_loaded  = 0;
        end
      end else if (!seen_now && seen_prev) begin
        m_loading = 0;
      end else if (bus.strobe) begin
        if (m_taken % 2 == 0) m_op = bus.data_in;
        else m_mem[m_taken / 2] = {m_op, bus.data_in};
        m_taken++;
        if (m_taken == 16) begin
          m_taken   = 0;
          m_loading = 0;
          m_loaded  = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      logic [7:0] slot;
      logic [1:0] st;
      slot = m_mem[bus.fetch_addr];
      st   = !m_loading ? 2'b00 : ((m_taken % 2 == 0) ? 2'b01 : 2'b10);
      check("load_state",   {30'd0, bus.load_state}, {30'd0, st});
      check("cpu_hold",     {31'd0, bus.cpu_hold},   {31'd0, m_loading});
      check("loaded",       {31'd0, bus.loaded},     {31'd0, m_loaded});
      check("wr_addr",      {29'd0, bus.wr_addr},    m_taken / 2);
      check("fetch_opcode", {28'd0, bus.fetch_opcode}, {28'd0, slot[7:4]});
      check("fetch_arg",    {28'd0, bus.fetch_arg},    {28'd0, slot[3:0]});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe_nib(input logic [3:0] d);
    bus.data_in = d;
    bus.strobe  = 1'b1;
    tick();
    bus.strobe  = 1'b0;
  endtask

  task automatic read_slot(input logic [2:0] k, input logic [7:0] exp, input string name);
    bus.fetch_addr = k;
    #1;
    check(name, {24'd0, bus.fetch_opcode, bus.fetch_arg}, {24'd0, exp});
    tick();
  endtask

  task automatic start_load();
    bus.load_en = 1'b1;
    tick();
    tick();
    check("sync_lat_2edges", {30'd0, bus.load_state}, 32'd0);
    tick();
    check("sync_lat_3edges", {30'd0, bus.load_state}, 32'd1);
    check("hold_on_load",    {31'd0, bus.cpu_hold},   32'd1);
  endtask

  initial begin
    reset_n        = 1'b0;
    bus.load_en    = 1'b0;
    bus.strobe     = 1'b0;
    bus.data_in    = 4'h0;
    bus.fetch_addr = 3'd0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // Reset state and cleared memory
    check("rst_state",  {30'd0, bus.load_state}, 32'd0);
    check("rst_hold",   {31'd0, bus.cpu_hold},   32'd0);
    check("rst_loaded", {31'd0, bus.loaded},     32'd0);
    for (int k = 0; k < 8; k++) read_slot(3'(k), 8'h00, "rst_slot");

    // Full load with opcode k+8, arg k
    start_load();
    for (int k = 0; k < 8; k++) begin
      strobe_nib(4'(k + 8));
      strobe_nib(4'(k));
    end
    check("full_loaded",  {31'd0, bus.loaded},     32'd1);
    check("full_hold",    {31'd0, bus.cpu_hold},   32'd0);
    check("full_state",   {30'd0, bus.load_state}, 32'd0);
    check("full_wr_addr", {29'd0, bus.wr_addr},    32'd0);
    for (int k = 0; k < 8; k++) read_slot(3'(k), {4'(k + 8), 4'(k)}, "full_slot");

    // Held load_en: RUN strobes ignored, no new load
    for (int i = 0; i < 5; i++) strobe_nib(4'hF);
    repeat (3) tick();
    check("held_state",  {30'd0, bus.load_state}, 32'd0);
    check("held_loaded", {31'd0, bus.loaded},     32'd1);
    read_slot(3'd3, 8'hB3, "held_slot3");
    read_slot(3'd7, 8'hF7, "held_slot7");

    // Abort after slot 2 opcode
    bus.load_en = 1'b0;
    repeat (3) tick();
    start_load();
    strobe_nib(4'hA); strobe_nib(4'h5);
    strobe_nib(4'h3); strobe_nib(4'hC);
    strobe_nib(4'h7);
    bus.load_en = 1'b0;
    repeat (3) tick();
    check("abort_state",   {30'd0, bus.load_state}, 32'd0);
    check("abort_loaded",  {31'd0, bus.loaded},     32'd0);
    check("abort_wr_addr", {29'd0, bus.wr_addr},    32'd2);
    read_slot(3'd0, 8'hA5, "abort_slot0");
    read_slot(3'd1, 8'h3C, "abort_slot1");
    read_slot(3'd2, 8'hA2, "abort_slot2");

    // Strobe on the same edge the synchronized fall arrives
    start_load();
    strobe_nib(4'h1);
    bus.load_en = 1'b0;
    tick();
    tick();
    strobe_nib(4'h6);
    check("coll_state", {30'd0, bus.load_state}, 32'd0);
    read_slot(3'd0, 8'hA5, "coll_slot0");
    tick();

    // Async reset mid-cycle during LOAD_ARG
    start_load();
    strobe_nib(4'h2);
    check("pre_rst_state", {30'd0, bus.load_state}, 32'd2);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_state",  {30'd0, bus.load_state}, 32'd0);
    check("arst_hold",   {31'd0, bus.cpu_hold},   32'd0);
    check("arst_loaded", {31'd0, bus.loaded},     32'd0);
    tick();
    for (int k = 0; k < 8; k++) read_slot(3'(k), 8'h00, "arst_slot");
    bus.load_en = 1'b0;
    reset_n = 1'b1;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
